// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, taken-branch front-end flush and data-memory freeze with timeout.
// Optional PIPE_PERF_CNT_EN adds stall_cycles/flush_cycles performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W     = 5,
    parameter int BRANCH_PENALTY = 2,
    parameter int MAX_MEM_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memread,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  idex_we,
    output logic                  exmem_we,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic [1:0]            ctrl_state,
    output logic                  mem_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_cycles
`endif
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] ret_q, ret_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic [1:0] eval_state;
    logic       hazard;

    assign hazard = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves a latch.
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        state_d     = state_q;
        ret_d       = ret_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        eval_state  = state_q;

        // Leaving the freeze re-evaluates the interrupted state with the current inputs.
        if (state_q == S_MEM_WAIT) begin
            if (mem_busy) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (wait_cnt_d == 8'(MAX_MEM_WAIT)) begin
                    timeout_d = 1'b1;
                    state_d   = S_RUN;
                end
            end else begin
                eval_state = ret_q;
            end
        end

        case (eval_state)
            S_RUN: begin
                if (mem_busy) begin
                    ret_d      = S_RUN;
                    wait_cnt_d = 8'd1;
                    state_d    = S_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    {pc_we, ifid_we, idex_we, exmem_we} = 4'b1111;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        flush_cnt_d = 3'(BRANCH_PENALTY - 1);
                        state_d     = S_FLUSH;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (hazard) begin
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = S_RUN;
                end else begin
                    {pc_we, ifid_we, idex_we, exmem_we} = 4'b1111;
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (mem_busy) begin
                    ret_d      = S_FLUSH;
                    wait_cnt_d = 8'd1;
                    state_d    = S_MEM_WAIT;
                end else begin
                    {pc_we, ifid_we, idex_we, exmem_we} = 4'b1111;
                    ifid_flush  = 1'b1;
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    state_d     = (flush_cnt_q == 3'd1) ? S_RUN : S_FLUSH;
                end
            end
            S_MEM_WAIT: begin
                // Busy freeze: all controls stay low, counters handled above.
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        if (reset) begin
            {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    // State moves on the falling edge together with the pipeline registers.
    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state_q     <= S_RUN;
            ret_q       <= S_RUN;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ctrl_state  = state_q;
    assign mem_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_cycles_q;

    always_ff @(negedge clk) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_cycles_q <= 32'd0;
        end else begin
            if (!pc_we)     stall_cycles_q <= stall_cycles_q + 32'd1;
            if (ifid_flush) flush_cycles_q <= flush_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default parameters: BRANCH_PENALTY=2, MAX_MEM_WAIT=15).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, mem_busy;
    logic       pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush;
    logic [1:0] ctrl_state;
    logic       mem_timeout;
    logic [5:0] ctl;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush}
    localparam logic [5:0] C_RESET  = 6'b0000_11;
    localparam logic [5:0] C_RUN    = 6'b1111_00;
    localparam logic [5:0] C_FREEZE = 6'b0000_00;
    localparam logic [5:0] C_BRANCH = 6'b1111_11;
    localparam logic [5:0] C_HAZARD = 6'b0011_01;
    localparam logic [5:0] C_FLUSH  = 6'b1111_10;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .idex_we         (idex_we),
        .exmem_we        (exmem_we),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .ctrl_state      (ctrl_state),
        .mem_timeout     (mem_timeout)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
`endif
    );

    assign ctl = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush};

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs are already applied; sample mid-cycle (rising edge), then step past the falling edge.
    task automatic cyc(input string tag, input logic [5:0] exp_ctl, input logic [1:0] exp_st,
                       input logic exp_to);
        @(posedge clk);
        check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
        check({tag, "_st"},  32'(ctrl_state), 32'(exp_st));
        check({tag, "_to"},  32'(mem_timeout), 32'(exp_to));
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;

        // Reset held for three edges: we=0, flushes forced high.
        cyc("rst0", C_RESET, 2'd0, 1'b0);
        cyc("rst1", C_RESET, 2'd0, 1'b0);
        reset = 1'b0;
        cyc("idle", C_RUN, 2'd0, 1'b0);

        // Load-use hazards on rs2 and rs1, plus non-stalling near misses.
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        cyc("haz_rs2", C_HAZARD, 2'd0, 1'b0);
        ex_memread = 1'b0;
        cyc("haz_clr", C_RUN, 2'd0, 1'b0);
        idle_inputs();
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        cyc("haz_rs1", C_HAZARD, 2'd0, 1'b0);
        id_use_rs1 = 1'b0;
        cyc("haz_nouse", C_RUN, 2'd0, 1'b0);
        ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cyc("haz_x0", C_RUN, 2'd0, 1'b0);
        idle_inputs();

        // Taken branch; a second branch during FLUSH is ignored.
        ex_branch_taken = 1'b1;
        cyc("br0", C_BRANCH, 2'd0, 1'b0);
        cyc("br1_ign", C_FLUSH, 2'd1, 1'b0);
        ex_branch_taken = 1'b0;
        cyc("br2", C_RUN, 2'd0, 1'b0);

        // Hazard during FLUSH is ignored too.
        ex_branch_taken = 1'b1;
        cyc("brh0", C_BRANCH, 2'd0, 1'b0);
        ex_branch_taken = 1'b0;
        ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        cyc("brh1", C_FLUSH, 2'd1, 1'b0);
        idle_inputs();
        cyc("brh2", C_RUN, 2'd0, 1'b0);

        // Four busy cycles with a branch held; branch serviced on the exit cycle.
        mem_busy = 1'b1; ex_branch_taken = 1'b1;
        cyc("mw0", C_FREEZE, 2'd0, 1'b0);
        cyc("mw1", C_FREEZE, 2'd2, 1'b0);
        cyc("mw2", C_FREEZE, 2'd2, 1'b0);
        cyc("mw3", C_FREEZE, 2'd2, 1'b0);
        mem_busy = 1'b0;
        cyc("mw_exit", C_BRANCH, 2'd2, 1'b0);
        ex_branch_taken = 1'b0;
        cyc("mw_fl", C_FLUSH, 2'd1, 1'b0);
        cyc("mw_run", C_RUN, 2'd0, 1'b0);

        // Freeze in the middle of FLUSH (flush_cnt=1), then resume FLUSH for one cycle.
        ex_branch_taken = 1'b1;
        cyc("fz_br", C_BRANCH, 2'd0, 1'b0);
        ex_branch_taken = 1'b0; mem_busy = 1'b1;
        cyc("fz0", C_FREEZE, 2'd1, 1'b0);
        cyc("fz1", C_FREEZE, 2'd2, 1'b0);
        mem_busy = 1'b0;
        cyc("fz_exit", C_FLUSH, 2'd2, 1'b0);
        cyc("fz_run", C_RUN, 2'd0, 1'b0);

        // Stuck busy: timeout appears after the 15th busy cycle, freeze persists.
        mem_busy = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            cyc($sformatf("to_%0d", i), C_FREEZE, (i == 1) ? 2'd0 : 2'd2, 1'b0);
        end
        cyc("to_16", C_FREEZE, 2'd0, 1'b1);
        cyc("to_17", C_FREEZE, 2'd2, 1'b1);
        mem_busy = 1'b0;
        cyc("to_exit", C_RUN, 2'd2, 1'b1);
        cyc("to_sticky", C_RUN, 2'd0, 1'b1);

        // Only reset clears the sticky flag.
        reset = 1'b1;
        cyc("rst2", C_RESET, 2'd0, 1'b1);
        reset = 1'b0;
        cyc("post_rst", C_RUN, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
